// File: rtl/vector_reducer_pkg.sv
// Shared types and saturation bounds for the frame-level vector reducer.
`timescale 1ns/1ps
package vector_reducer_pkg;

   typedef enum logic [1:0] {
      OP_SUM  = 2'b00,
      OP_MAX  = 2'b01,
      OP_MIN  = 2'b10,
      OP_RSVD = 2'b11
   } reduce_op_e;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_e;

   localparam int unsigned MAX_DATA_WIDTH = 64;

   // Largest representable signed value for a lane of the given width.
   function automatic logic signed [MAX_DATA_WIDTH-1:0] sat_max(input int unsigned width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [MAX_DATA_WIDTH-1:0] sat_min(input int unsigned width);
      return -(64'sd1 <<< (width - 1));
   endfunction

endpackage

// File: rtl/vector_reducer_lane.sv
// One lane of the reducer: combines the running accumulator with a new sample.
`timescale 1ns/1ps
module reduce_lane
   import vector_reducer_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] acc,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [1:0]            op,
   input  logic                  load,
   output logic [DATA_WIDTH-1:0] next_acc,
   output logic                  sat
);

   localparam logic [DATA_WIDTH-1:0] SAT_HI = DATA_WIDTH'(sat_max(DATA_WIDTH));
   localparam logic [DATA_WIDTH-1:0] SAT_LO = DATA_WIDTH'(sat_min(DATA_WIDTH));

   logic [DATA_WIDTH:0] sum;
   logic                acc_gt_data;

   // One guard bit: the two top bits disagree exactly when the sum left the lane range.
   assign sum         = {acc[DATA_WIDTH-1], acc} + {data[DATA_WIDTH-1], data};
   assign acc_gt_data = $signed(acc) > $signed(data);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      next_acc = data;
      sat      = 1'b0;
      if (!load) begin
         case (reduce_op_e'(op))
            OP_MAX: next_acc = acc_gt_data ? acc : data;
            OP_MIN: next_acc = acc_gt_data ? data : acc;
            default: begin
               if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
                  sat      = 1'b1;
                  next_acc = sum[DATA_WIDTH] ? SAT_LO : SAT_HI;
               end else begin
                  next_acc = sum[DATA_WIDTH-1:0];
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/vector_reducer.sv
// Reduces every vector of a frame lane-by-lane (sum/max/min) and emits one result per frame.
`timescale 1ns/1ps
module vector_reducer
   import vector_reducer_pkg::*;
#(
   parameter int N           = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic                   valid_in,
   input  logic                   eof_in,
   input  logic [DATA_WIDTH-1:0]  vector_in [N-1:0],
   input  logic [1:0]             op_in,
   output logic                   valid_out,
   output logic [DATA_WIDTH-1:0]  vector_out [N-1:0],
   output logic [COUNT_WIDTH-1:0] count_out,
   output logic                   overflow_out
);

   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   state_e                 state;
   logic [DATA_WIDTH-1:0]  acc      [N-1:0];
   logic [DATA_WIDTH-1:0]  next_acc [N-1:0];
   logic [N-1:0]           lane_sat;
   logic [1:0]             frame_op;
   logic [1:0]             lane_op;
   logic                   frame_ovf;
   logic                   next_ovf;
   logic                   load;
   logic [COUNT_WIDTH-1:0] count;
   logic [COUNT_WIDTH-1:0] next_count;

   // The first vector of a frame overwrites the accumulators and uses the live op.
   assign load       = (state == IDLE);
   assign lane_op    = load ? op_in : frame_op;
   assign next_ovf   = (frame_ovf & ~load) | (|lane_sat);
   assign next_count = load ? COUNT_ONE
                     : (count == COUNT_MAX) ? count : count + COUNT_ONE;

   for (genvar i = 0; i < N; i++) begin : g_lane
      reduce_lane #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_lane (
         .acc      (acc[i]),
         .data     (vector_in[i]),
         .op       (lane_op),
         .load     (load),
         .next_acc (next_acc[i]),
         .sat      (lane_sat[i])
      );
   end

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state        <= IDLE;
         count        <= '0;
         frame_op     <= OP_SUM;
         frame_ovf    <= 1'b0;
         valid_out    <= 1'b0;
         count_out    <= '0;
         overflow_out <= 1'b0;
         // NOTE: the lane arrays are plain flops, not RAM, so resetting them element-wise is intended.
         for (int i = 0; i < N; i++) begin
            acc[i]        <= '0;
            vector_out[i] <= '0;
         end
      end else begin
         valid_out <= 1'b0;
         if (valid_in) begin
            for (int i = 0; i < N; i++) acc[i] <= next_acc[i];
            count     <= next_count;
            frame_ovf <= next_ovf;
            if (load) frame_op <= op_in;
            if (eof_in) begin
               state        <= IDLE;
               valid_out    <= 1'b1;
               count_out    <= next_count;
               overflow_out <= next_ovf;
               for (int i = 0; i < N; i++) vector_out[i] <= next_acc[i];
            end else begin
               state <= ACCUM;
            end
         end
      end
   end

endmodule

// File: tb/tb_vector_reducer.sv
// Self-checking bench: directed frames with literal expectations plus random frames against a frame-level model.
`timescale 1ns/1ps
module tb_vector_reducer;

   localparam int N  = 8;
   localparam int DW = 32;
   localparam int CW = 16;
   localparam longint LANE_MAX  = 64'sd2147483647;
   localparam longint LANE_MIN  = -64'sd2147483648;
   localparam longint COUNT_SAT = 65535;

   logic          clk_in;
   logic          rst_n_in;
   logic          valid_in;
   logic          eof_in;
   logic [DW-1:0] vector_in [N-1:0];
   logic [1:0]    op_in;
   logic          valid_out;
   logic [DW-1:0] vector_out [N-1:0];
   logic [CW-1:0] count_out;
   logic          overflow_out;

   int checks   = 0;
   int failures = 0;

   vector_reducer #(.N(N), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .valid_in     (valid_in),
      .eof_in       (eof_in),
      .vector_in    (vector_in),
      .op_in        (op_in),
      .valid_out    (valid_out),
      .vector_out   (vector_out),
      .count_out    (count_out),
      .overflow_out (overflow_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   typedef longint vec_t [N];
   vec_t       frame_q [$];
   vec_t       cur;
   logic [1:0] frame_op;
   bit         in_frame;
   bit         exp_valid;
   longint     exp_vec [N];
   longint     exp_count;
   bit         exp_ovf;
   longint     m_acc;
   longint     m_sum;
   bit         m_ovf;

   // Combine the stored frame in arrival order with the op latched at its first vector.
   task automatic reduce_frame();
      m_ovf = 1'b0;
      for (int l = 0; l < N; l++) begin
         m_acc = frame_q[0][l];
         for (int k = 1; k < frame_q.size(); k++) begin
            case (frame_op)
               2'b01: if (frame_q[k][l] > m_acc) m_acc = frame_q[k][l];
               2'b10: if (frame_q[k][l] < m_acc) m_acc = frame_q[k][l];
               default: begin
                  m_sum = m_acc + frame_q[k][l];
                  if (m_sum > LANE_MAX) begin
                     m_sum = LANE_MAX;
                     m_ovf = 1'b1;
                  end else if (m_sum < LANE_MIN) begin
                     m_sum = LANE_MIN;
                     m_ovf = 1'b1;
                  end
                  m_acc = m_sum;
               end
            endcase
         end
         exp_vec[l] = m_acc;
      end
      exp_ovf   = m_ovf;
      exp_count = (frame_q.size() > COUNT_SAT) ? COUNT_SAT : longint'(frame_q.size());
   endtask

   always @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         in_frame  = 1'b0;
         frame_q.delete();
         exp_valid = 1'b0;
         exp_count = 0;
         exp_ovf   = 1'b0;
         for (int l = 0; l < N; l++) exp_vec[l] = 0;
      end else begin
         exp_valid = 1'b0;
         if (valid_in) begin
            if (!in_frame) begin
               frame_q.delete();
               frame_op = op_in;
               in_frame = 1'b1;
            end
            for (int l = 0; l < N; l++) cur[l] = $signed(vector_in[l]);
            frame_q.push_back(cur);
            if (eof_in) begin
               reduce_frame();
               exp_valid = 1'b1;
               in_frame  = 1'b0;
            end
         end
      end
   end

   // ---------------- per-cycle compare + result log ----------------
   typedef struct {
      longint lane0;
      longint lane7;
      longint count;
      longint ovf;
   } res_t;
   res_t log_q [$];

   always @(negedge clk_in) begin
      if (rst_n_in) begin
         check("valid_out", valid_out, exp_valid);
         check("count_out", count_out, exp_count);
         check("overflow_out", overflow_out, exp_ovf);
         for (int l = 0; l < N; l++)
            check($sformatf("vector_out[%0d]", l), $signed(vector_out[l]), exp_vec[l]);
         if (valid_out)
            log_q.push_back('{$signed(vector_out[0]), $signed(vector_out[N-1]),
                              longint'(count_out), longint'(overflow_out)});
      end
   end

   task automatic check_log(input string name, input int idx, input longint lane,
                            input longint cnt, input longint ovf);
      if (log_q.size() > idx) begin
         check({name, "_lane0"}, log_q[idx].lane0, lane);
         check({name, "_lane7"}, log_q[idx].lane7, lane);
         check({name, "_count"}, log_q[idx].count, cnt);
         check({name, "_ovf"}, log_q[idx].ovf, ovf);
      end else begin
         check({name, "_present"}, log_q.size(), idx + 1);
      end
   endtask

   // ---------------- stimulus ----------------
   task automatic send(input logic v, input logic e, input int val, input logic [1:0] op);
      @(negedge clk_in);
      valid_in = v;
      eof_in   = e;
      op_in    = op;
      for (int l = 0; l < N; l++) vector_in[l] = val;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_in);
         valid_in = 1'b0;
         eof_in   = 1'b0;
      end
   endtask

   function automatic logic [DW-1:0] rand_val();
      case ($urandom_range(0, 3))
         0:       return 32'($urandom_range(0, 200)) - 32'd100;
         1:       return 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
         2:       return 32'h8000_0000 + 32'($urandom_range(0, 255));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic send_rand(input logic v, input logic e, input logic [1:0] op);
      @(negedge clk_in);
      valid_in = v;
      eof_in   = e;
      op_in    = op;
      for (int l = 0; l < N; l++) vector_in[l] = rand_val();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int         len;
      logic [1:0] fop;

      rst_n_in = 1'b1;
      valid_in = 1'b0;
      eof_in   = 1'b0;
      op_in    = 2'b00;
      for (int l = 0; l < N; l++) vector_in[l] = '0;
      #1 rst_n_in = 1'b0;
      repeat (2) @(negedge clk_in);
      check("reset_valid", valid_out, 0);
      check("reset_count", count_out, 0);
      check("reset_ovf", overflow_out, 0);
      check("reset_lane0", $signed(vector_out[0]), 0);
      rst_n_in = 1'b1;
      idle(2);

      // SUM of 1,2,3
      log_q.delete();
      send(1, 0, 1, 2'b00);
      send(1, 0, 2, 2'b00);
      send(1, 1, 3, 2'b00);
      idle(3);
      check_log("sum3", 0, 6, 3, 0);
      check("sum3_pulses", log_q.size(), 1);

      // MIN with gaps; a stray eof without valid and an op change must be ignored
      log_q.delete();
      send(1, 0, 5, 2'b10);
      send(0, 1, 99, 2'b10);
      send(1, 0, -7, 2'b10);
      idle(2);
      send(1, 1, 2, 2'b11);
      idle(3);
      check_log("min", 0, -7, 3, 0);

      // MAX with op_in changing mid-frame
      log_q.delete();
      send(1, 0, 5, 2'b01);
      idle(1);
      send(1, 0, -7, 2'b00);
      send(1, 1, 2, 2'b10);
      idle(3);
      check_log("max", 0, 5, 3, 0);

      // Positive saturation, then a clean frame clears the flag
      log_q.delete();
      send(1, 0, 32'h7FFF_FFF0, 2'b00);
      send(1, 1, 32'h0000_0020, 2'b00);
      send(1, 0, 1, 2'b00);
      send(1, 1, 1, 2'b00);
      idle(3);
      check_log("sat", 0, 2147483647, 2, 1);
      check_log("nosat", 1, 2, 2, 0);

      // Back-to-back single-vector frames
      log_q.delete();
      send(1, 1, 4, 2'b00);
      send(1, 1, 9, 2'b01);
      send(1, 1, -1, 2'b10);
      idle(3);
      check("b2b_pulses", log_q.size(), 3);
      check_log("b2b0", 0, 4, 1, 0);
      check_log("b2b1", 1, 9, 1, 0);
      check_log("b2b2", 2, -1, 1, 0);

      // Asynchronous reset in the middle of a frame
      log_q.delete();
      send(1, 0, 10, 2'b00);
      send(1, 0, 10, 2'b00);
      @(posedge clk_in);
      #2 valid_in = 1'b0;
      rst_n_in = 1'b0;
      #1;
      check("rst_mid_valid", valid_out, 0);
      check("rst_mid_count", count_out, 0);
      check("rst_mid_lane0", $signed(vector_out[0]), 0);
      check("rst_mid_ovf", overflow_out, 0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      send(1, 0, 10, 2'b00);
      send(1, 1, 10, 2'b00);
      idle(3);
      check("rst_pulses", log_q.size(), 1);
      check_log("rst_after", 0, 20, 2, 0);

      // Random frames: random ops (including reserved), gaps, stray eofs, mid-frame op noise
      repeat (400) begin
         len = $urandom_range(1, 6);
         fop = 2'($urandom_range(0, 3));
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 2) == 0)
               repeat ($urandom_range(1, 2)) send_rand(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            send_rand(1'b1, (k == len - 1), (k == 0) ? fop : 2'($urandom_range(0, 3)));
         end
      end
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
